// File: rtl/dfr_pkg.sv
// Shared DFR definitions: matrix-multiply state encoding and accumulator sizing.
package dfr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    DRAIN,
    WRITE
  } mm_state_t;

  // Wide enough to sum k full-width signed products without overflow.
  function automatic int mm_acc_width(input int data_width, input int k);
    return 2 * data_width + $clog2(k + 1);
  endfunction

endpackage

// File: rtl/dfr_mac.sv
// Signed multiply-accumulate used by the matrix multiplier; one product per enabled cycle.
module dfr_mac #(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 67
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         en,
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic signed [ACC_WIDTH-1:0]  acc
);

  logic signed [2*DATA_WIDTH-1:0] product;

  assign product = a * b;

  // Clear wins over enable so a new element never inherits the previous sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_WIDTH'(product);
    end
  end

endmodule

// File: rtl/dfr_matrix_multiply.sv
// Computes Y = X * W over synchronous-read memories; one Y element per K+2 cycles.
module dfr_matrix_multiply
  import dfr_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int X_ROWS        = 5,
  parameter int Y_COLS        = 5,
  parameter int X_COLS_Y_ROWS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  x_rd_en,
  output logic [ADDR_WIDTH-1:0] x_addr,
  input  logic [DATA_WIDTH-1:0] x_data,
  output logic                  w_rd_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic                  y_we,
  output logic [ADDR_WIDTH-1:0] y_addr,
  output logic [DATA_WIDTH-1:0] y_data
);

  localparam int K     = X_COLS_Y_ROWS;
  localparam int ACC_W = mm_acc_width(DATA_WIDTH, K);

  localparam logic [ADDR_WIDTH-1:0] K_LAST = ADDR_WIDTH'(K - 1);
  localparam logic [ADDR_WIDTH-1:0] J_LAST = ADDR_WIDTH'(Y_COLS - 1);
  localparam logic [ADDR_WIDTH-1:0] I_LAST = ADDR_WIDTH'(X_ROWS - 1);
  localparam logic [ADDR_WIDTH-1:0] K_STEP = ADDR_WIDTH'(K);
  localparam logic [ADDR_WIDTH-1:0] J_STEP = ADDR_WIDTH'(Y_COLS);

  mm_state_t state;

  logic [ADDR_WIDTH-1:0] i_cnt;
  logic [ADDR_WIDTH-1:0] j_cnt;
  logic [ADDR_WIDTH-1:0] k_cnt;
  logic [ADDR_WIDTH-1:0] x_row_base;
  logic [ADDR_WIDTH-1:0] y_row_base;
  logic [ADDR_WIDTH-1:0] w_col_off;
  logic                  valid;

  logic                    mac_clear;
  logic                    mac_en;
  logic signed [ACC_W-1:0] acc;
  logic                    unused_acc_hi;

  // Read data lags the strobe by one cycle, so the MAC only adds once valid is set.
  assign x_rd_en   = (state == MAC);
  assign w_rd_en   = (state == MAC);
  assign x_addr    = x_row_base + k_cnt;
  assign w_addr    = w_col_off + j_cnt;
  assign y_we      = (state == WRITE);
  assign y_addr    = y_row_base + j_cnt;
  assign y_data    = acc[DATA_WIDTH-1:0];
  assign mac_clear = ((state == IDLE) && start) || (state == WRITE);
  assign mac_en    = ((state == MAC) && valid) || (state == DRAIN);

  assign unused_acc_hi = ^acc[ACC_W-1:DATA_WIDTH];

  dfr_mac #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_W)
  ) u_mac (
    .clk  (clk),
    .rst  (rst),
    .clear(mac_clear),
    .en   (mac_en),
    .a    ($signed(x_data)),
    .b    ($signed(w_data)),
    .acc  (acc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      i_cnt      <= '0;
      j_cnt      <= '0;
      k_cnt      <= '0;
      x_row_base <= '0;
      y_row_base <= '0;
      w_col_off  <= '0;
      valid      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= MAC;
            busy       <= 1'b1;
            i_cnt      <= '0;
            j_cnt      <= '0;
            k_cnt      <= '0;
            x_row_base <= '0;
            y_row_base <= '0;
            w_col_off  <= '0;
            valid      <= 1'b0;
          end
        end
        MAC: begin
          valid     <= 1'b1;
          k_cnt     <= k_cnt + 1'b1;
          w_col_off <= w_col_off + J_STEP;
          if (k_cnt == K_LAST) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          valid <= 1'b0;
          state <= WRITE;
        end
        WRITE: begin
          k_cnt     <= '0;
          w_col_off <= '0;
          if (j_cnt == J_LAST) begin
            j_cnt <= '0;
            if (i_cnt == I_LAST) begin
              i_cnt      <= '0;
              x_row_base <= '0;
              y_row_base <= '0;
              state      <= IDLE;
              busy       <= 1'b0;
              done       <= 1'b1;
            end else begin
              i_cnt      <= i_cnt + 1'b1;
              x_row_base <= x_row_base + K_STEP;
              y_row_base <= y_row_base + J_STEP;
              state      <= MAC;
            end
          end else begin
            j_cnt <= j_cnt + 1'b1;
            state <= MAC;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dfr_matrix_multiply.sv
// Self-checking bench: memory models, a matrix-product reference and a write scoreboard.
module tb_dfr_matrix_multiply;

  localparam int N = 5;
  localparam int BUSY_LEN = N * N * (N + 2);

  logic        clk;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic        x_rd_en;
  logic [31:0] x_addr;
  logic [31:0] x_data;
  logic        w_rd_en;
  logic [31:0] w_addr;
  logic [31:0] w_data;
  logic        y_we;
  logic [31:0] y_addr;
  logic [31:0] y_data;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic [31:0] xmem[N*N];
  logic [31:0] wmem[N*N];
  logic [31:0] ymodel[N*N];
  wr_t         expq[$];
  int          total;
  int          bad;

  dfr_matrix_multiply dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .busy   (busy),
    .done   (done),
    .x_rd_en(x_rd_en),
    .x_addr (x_addr),
    .x_data (x_data),
    .w_rd_en(w_rd_en),
    .w_addr (w_addr),
    .w_data (w_data),
    .y_we   (y_we),
    .y_addr (y_addr),
    .y_data (y_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memories: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (x_rd_en) x_data <= (x_addr < N*N) ? xmem[x_addr] : 32'h0;
    if (w_rd_en) w_data <= (w_addr < N*N) ? wmem[w_addr] : 32'h0;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every write must be the next element the reference predicts.
  always @(negedge clk) begin
    if (y_we) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_write: got addr %0h data %0h expected none at %0t", y_addr, y_data, $time);
      end else begin
        wr_t e;
        e = expq.pop_front();
        checkOutput("y_addr", y_addr, e.addr);
        checkOutput("y_data", y_data, e.data);
      end
    end
  end

  task automatic applyStimulus(input int mode);
    for (int idx = 0; idx < N*N; idx++) begin
      case (mode)
        0: begin xmem[idx] = 32'd1;                 wmem[idx] = 32'd2; end
        1: begin xmem[idx] = 32'(idx % N + 1);      wmem[idx] = (idx / N == idx % N) ? 32'd1 : 32'd0; end
        2: begin xmem[idx] = 32'hFFFF_FFFD;         wmem[idx] = 32'd4; end
        3: begin xmem[idx] = 32'h0001_0000;         wmem[idx] = 32'h0001_0000; end
        default: begin xmem[idx] = $urandom;        wmem[idx] = $urandom; end
      endcase
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        longint sum;
        wr_t e;
        sum = 0;
        for (int k = 0; k < N; k++) begin
          sum += longint'($signed(xmem[i*N+k])) * longint'($signed(wmem[k*N+j]));
        end
        ymodel[i*N+j] = sum[31:0];
        e.addr = 32'(i*N + j);
        e.data = sum[31:0];
        expq.push_back(e);
      end
    end
  endtask

  // Call at a negedge; returns at the negedge where busy is first seen low.
  task automatic runMultiply(input int pokeCycle, input bit chained);
    int cycles;
    bit finished;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_after_start", {31'b0, busy}, 32'd1);
    cycles = 1;
    finished = 1'b0;
    for (int n = 0; n < 1000 && !finished; n++) begin
      start = (cycles == pokeCycle);
      @(negedge clk);
      if (!busy) finished = 1'b1;
      else cycles++;
    end
    start = 1'b0;
    checkOutput("busy_timeout", {31'b0, finished}, 32'd1);
    checkOutput("busy_len", 32'(cycles), 32'(BUSY_LEN));
    checkOutput("done_pulse", {31'b0, done}, 32'd1);
    checkOutput("writes_left", 32'(expq.size()), 32'd0);
    if (!chained) begin
      @(negedge clk);
      checkOutput("done_single", {31'b0, done}, 32'd0);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_done", {31'b0, done}, 32'd0);
    checkOutput("rst_y_we", {31'b0, y_we}, 32'd0);
    checkOutput("rst_x_rd_en", {31'b0, x_rd_en}, 32'd0);
    checkOutput("rst_y_data", y_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(0);
    checkOutput("model_pin_ones", ymodel[0], 32'd10);
    runMultiply(-1, 1'b0);

    applyStimulus(1);
    checkOutput("model_pin_identity", ymodel[7], 32'd3);
    runMultiply(-1, 1'b0);

    applyStimulus(2);
    checkOutput("model_pin_negative", ymodel[24], 32'hFFFF_FFC4);
    runMultiply(-1, 1'b0);

    applyStimulus(3);
    checkOutput("model_pin_wrap", ymodel[12], 32'd0);
    runMultiply(-1, 1'b1);

    // Start issued in the done cycle must launch the next multiply.
    applyStimulus(4);
    runMultiply(-1, 1'b0);

    applyStimulus(0);
    runMultiply(50, 1'b0);

    applyStimulus(4);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (59) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("abort_busy", {31'b0, busy}, 32'd0);
    checkOutput("abort_y_we", {31'b0, y_we}, 32'd0);
    checkOutput("abort_done", {31'b0, done}, 32'd0);
    expq.delete();
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("idle_after_abort", {31'b0, busy}, 32'd0);

    for (int r = 0; r < 2; r++) begin
      applyStimulus(4);
      runMultiply(-1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
